// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: access sizes, sequencer
// states, requester ids and the size-to-byte-count helper.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Size code 3 is illegal and served as a full word.
    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks N consecutive RAM byte addresses from a base, splitting
// a store word or assembling a little-endian load word, with rdy-stall replay.
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  start,
    input  logic                  we,
    input  logic [31:0]           base,
    input  logic [2:0]            n,
    input  logic [31:0]           wdata,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    input  logic [7:0]            ram_din,
    output logic                  done,
    output logic [31:0]           word,
    output state_e                state
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] lanes_q;
    logic [1:0]  last_q;
    logic [1:0]  iss_q;
    logic [1:0]  cap_q;
    logic        all_iss_q;
    logic        pend_q;

    logic [1:0]  idx;
    logic        issue;
    logic        capture;
    logic        rd_fin;
    logic        wr_fin;

    // While frozen in RD the address points back at the next byte to capture,
    // so the replay after the stall re-reads exactly the bytes not yet taken.
    always_comb begin
        idx     = (state_q == RD && !rdy) ? cap_q : iss_q;
        issue   = (state_q == RD) && rdy && !all_iss_q;
        capture = (state_q == RD) && rdy && pend_q;
        rd_fin  = capture && (cap_q == last_q);
        wr_fin  = (state_q == WR) && rdy && (iss_q == last_q);
        done    = rd_fin || wr_fin;
    end

    assign ram_a    = RAM_ADDR_W'(base_q + {30'd0, idx});
    assign ram_dout = 8'(wdata_q >> {iss_q, 3'b000});
    assign ram_wr   = (state_q == WR) && rdy;
    assign state    = state_q;

    always_comb begin
        word = lanes_q;
        if (capture) begin
            word[{cap_q, 3'b000} +: 8] = ram_din;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = we ? WR : RD;
            RD:      if (rd_fin) state_d = IDLE;
            WR:      if (wr_fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            wdata_q   <= '0;
            lanes_q   <= '0;
            last_q    <= '0;
            iss_q     <= '0;
            cap_q     <= '0;
            all_iss_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                base_q    <= base;
                wdata_q   <= wdata;
                lanes_q   <= '0;
                last_q    <= 2'(n - 3'd1);
                iss_q     <= '0;
                cap_q     <= '0;
                all_iss_q <= 1'b0;
                pend_q    <= 1'b0;
            end else if (state_q == RD) begin
                if (!rdy) begin
                    iss_q     <= cap_q;
                    all_iss_q <= 1'b0;
                    pend_q    <= 1'b0;
                end else begin
                    pend_q <= issue;
                    if (issue) begin
                        if (iss_q == last_q) all_iss_q <= 1'b1;
                        else                 iss_q     <= iss_q + 2'd1;
                    end
                    if (capture) begin
                        lanes_q <= word;
                        if (cap_q != last_q) cap_q <= cap_q + 2'd1;
                    end
                end
            end else if (state_q == WR && rdy && iss_q != last_q) begin
                iss_q <= iss_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the shared byte-wide RAM port between instruction fetch and MEM.
// Define MEM_ARB_FAIR_EN for round-robin arbitration; default is MEM-over-IF.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    input  logic [7:0]            ram_din
);

    // Handshake: a requester raises req with stable fields and holds it until
    // its one-cycle done pulse; it drops req the next cycle. The done cycle
    // itself never accepts, so a held req is not served twice.
    state_e      seq_state;
    logic        seq_start;
    logic        seq_done;
    logic [31:0] seq_word;
    logic        gnt_mem;
    logic [31:0] sel_addr;
    logic [2:0]  sel_n;
    logic        sel_we;
    req_id_e     owner_q;

    always_comb begin
        gnt_mem = mem_req;
`ifdef MEM_ARB_FAIR_EN
        if (mem_req && if_req) gnt_mem = (owner_q == REQ_IF);
`endif
        seq_start = (seq_state == IDLE) && rdy && !if_done && !mem_done
                    && (mem_req || if_req);
        sel_addr  = gnt_mem ? mem_addr : if_addr;
        sel_n     = gnt_mem ? size_to_n(mem_size) : 3'd4;
        sel_we    = gnt_mem && mem_we;
    end

    mem_byte_seq #(
        .RAM_ADDR_W(RAM_ADDR_W)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .start   (seq_start),
        .we      (sel_we),
        .base    (sel_addr),
        .n       (sel_n),
        .wdata   (mem_wdata),
        .ram_a   (ram_a),
        .ram_dout(ram_dout),
        .ram_wr  (ram_wr),
        .ram_din (ram_din),
        .done    (seq_done),
        .word    (seq_word),
        .state   (seq_state)
    );

    // owner_q both routes the completion and serves as the last-grant flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= REQ_IF;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (seq_start) owner_q <= gnt_mem ? REQ_MEM : REQ_IF;
            if (seq_done) begin
                if (owner_q == REQ_MEM) begin
                    mem_done <= 1'b1;
                    if (seq_state == RD) mem_rdata <= seq_word;
                end else begin
                    if_done <= 1'b1;
                    if_data <= seq_word;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter for the single byte-wide synchronous RAM port, shared by two requesters: the instruction-fetch stage (32-bit word reads) and the MEM stage (byte/half/word loads and stores).
- Serialises each access into consecutive byte cycles, assembles or splits little-endian words, and returns a one-cycle done pulse to the winning requester.
- Sits between the pipeline front/back ends and the RAM.

Parameters:
RAM_ADDR_W, 17, width of the RAM address output; the low bits of the 32-bit byte address are kept.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; 0 freezes the block
if_req  in  1  fetch request, level; held until if_done
if_addr  in  32  fetch byte address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
mem_req  in  1  load/store request, level; held until mem_done
mem_we  in  1  1 = store
mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal, treated as word
mem_addr  in  32  load/store byte address
mem_wdata  in  32  store data, low bytes used
mem_done  out  1  one-cycle pulse
mem_rdata  out  32  load data, zero-extended
ram_a  out  RAM_ADDR_W  RAM byte address
ram_dout  out  8  RAM write data
ram_wr  out  1  RAM write strobe
ram_din  in  8  RAM read data, valid one cycle after ram_a

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset state:
  - state = IDLE.
  - All outputs are 0, including if_data and mem_rdata.
  - Byte counters are cleared and the last-grant flag = IF.
- States:
  - IDLE: sample requests. mem_req has fixed priority over if_req. Load a base address and byte count N (1, 2 or 4; 4 for IF), then go to RD or WR.
  - RD: issue cycles 1..N drive ram_a = base+k, k = 0..N-1. Byte k is captured from ram_din in cycle k+2 into lane k (little-endian). The done pulse and data are registered in cycle N+2, then state returns to IDLE.
  - WR: cycles 1..N drive ram_a = base+k, ram_dout = mem_wdata byte k and ram_wr = 1. mem_done is asserted in cycle N+1, then state returns to IDLE.
- Latency, measured from the IDLE cycle in which the request is sampled (cycle 0):
  - word fetch: if_done in cycle 6.
  - byte load: mem_done in cycle 3.
  - byte store: mem_done in cycle 2.
- Handshake:
  - Done is asserted in the same cycle the state returns to IDLE.
  - A requester must deassert req in the cycle after seeing done.
  - Inputs must be stable while req is high.
  - IDLE never re-accepts in the done cycle.
- Address arithmetic:
  - base+k wraps modulo 2^32, then is truncated to RAM_ADDR_W bits.
  - Misaligned addresses are legal and served bytewise.
- Loads: unused upper lanes of mem_rdata are 0.
- Outputs hold their last value outside done. ram_wr = 0 whenever not in WR.
- rdy = 0:
  - State, counters and outputs are frozen; ram_wr is gated to 0 combinationally.
  - In RD, the issue index rewinds to the capture index and ram_a = base + capture index.
  - The first rdy = 1 cycle after a freeze captures nothing; issue then resumes.
  - No byte is lost, duplicated or written twice.
- Reset mid-access: the access is aborted with no done pulse. ram_wr = 0 from the next cycle.
- Both requests arriving in the cycle after a done: arbitration is normal (MEM wins).

Optional Feature:
MEM_ARB_FAIR_EN
- Defined: round-robin arbitration. When both requests are pending in IDLE, grant the requester not granted last time. The last-grant flag updates on every grant.
- Undefined: fixed MEM-over-IF priority. The flag logic is absent.

Decomposition:
- Shared package:
  - size encodings (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2)
  - state encodings IDLE/RD/WR
  - the requester-id constants REQ_IF/REQ_MEM
- One natural sub-module, mem_byte_seq:
  - takes base, N, we and wdata.
  - owns the issue/capture counters, ram_a/ram_dout/ram_wr, rdy rewind and lane assembly.
  - outputs done and word.
- The top level holds only the arbitration, the muxing of request fields and done/data routing to the requester.

Test Plan:
1. if_req = 1, if_addr = 0x100, RAM[0x100..0x103] = 11,22,33,44 -> ram_a = 0x100..0x103 in cycles 1..4; if_done in cycle 6 with if_data = 0x44332211; mem_done stays 0.
2. mem store, size = 2, addr = 0x200, wdata = 0xDEADBEEF -> ram_wr = 1 in cycles 1..4 with bytes EF,BE,AD,DE at 0x200..0x203; mem_done in cycle 5; a following half load from 0x202 returns 0x0000DEAD.
3. if_req and mem_req (byte load at 0x201) rise together -> MEM served first, mem_done in cycle 3 with 0x000000BE; IF accepted in cycle 4, if_done in cycle 10. With MEM_ARB_FAIR_EN and last grant = MEM, IF is served first instead.
4. Word fetch with rdy = 0 during cycles 3..5 -> no ram_wr; bytes are replayed; if_done arrives 4 cycles late with the correct word.
5. Store in progress, rst = 1 in cycle 2 -> ram_wr = 0 from cycle 3; no mem_done; all outputs 0; a new if_req after reset completes normally.
6. Word load at 0xFFFFFFFE with RAM_ADDR_W = 17 -> ram_a sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 (wrap).
